// File: rtl/fm_phase_discriminator.sv
// FM phase discriminator: per-channel wrapped phase difference, 2^DECIM_LOG2 averaging,
// AXI-Stream output register. Define FM_DEEMPH_EN to add one-pole de-emphasis per channel.
module fm_phase_discriminator #(
  parameter int ANGLE_WIDTH  = 16,
  parameter int NUM_CH       = 1,
  parameter int DECIM_LOG2   = 0,
  parameter int DEEMPH_SHIFT = 4
) (
  input  logic        s00_axis_aclk,
  input  logic        s00_axis_aresetn,
  input  logic        s00_axis_tvalid,
  output logic        s00_axis_tready,
  input  logic [31:0] s00_axis_tdata,
  input  logic        s00_axis_tlast,
  input  logic [3:0]  s00_axis_tstrb,
  output logic        m00_axis_tvalid,
  input  logic        m00_axis_tready,
  output logic [31:0] m00_axis_tdata,
  output logic        m00_axis_tlast,
  output logic [3:0]  m00_axis_tstrb
);
  localparam int W    = ANGLE_WIDTH;
  localparam int AW   = ANGLE_WIDTH + DECIM_LOG2;
  localparam int CHW  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int WINW = DECIM_LOG2 + 1;
  localparam logic [WINW-1:0] WIN_LAST = WINW'((1 << DECIM_LOG2) - 1);
  localparam logic [CHW-1:0]  CH_LAST  = CHW'(NUM_CH - 1);

  logic [W-1:0]         prev_q   [NUM_CH];
  logic [W-1:0]         prev_d   [NUM_CH];
  logic                 primed_q [NUM_CH];
  logic                 primed_d [NUM_CH];
  logic signed [AW-1:0] acc_q    [NUM_CH];
  logic signed [AW-1:0] acc_d    [NUM_CH];
  logic [WINW-1:0]      win_q    [NUM_CH];
  logic [WINW-1:0]      win_d    [NUM_CH];
  logic                 sticky_q [NUM_CH];
  logic                 sticky_d [NUM_CH];
`ifdef FM_DEEMPH_EN
  localparam int W1 = ANGLE_WIDTH + 1;
  logic signed [W-1:0]  y_q      [NUM_CH];
  logic signed [W-1:0]  y_d      [NUM_CH];
  logic signed [W1-1:0] dm_err;
  logic signed [W1-1:0] dm_y;
`endif

  logic [CHW-1:0] ch_q, ch_d;
  logic           m_valid_q, m_valid_d;
  logic           m_last_q, m_last_d;
  logic [15:0]    m_res_q, m_res_d;
  logic [7:0]     m_ch_q, m_ch_d;

  logic [W-1:0]         angle;
  logic                 accept;
  logic                 win_done;
  logic signed [W-1:0]  diff;
  logic signed [W-1:0]  avg;
  logic signed [W-1:0]  res;
  logic signed [AW-1:0] acc_sum;
  logic signed [AW-1:0] avg_full;
  logic                 unused;

  assign angle = s00_axis_tdata[31 -: W];
  assign s00_axis_tready = m00_axis_tready || !m_valid_q;
  assign accept = s00_axis_tvalid && s00_axis_tready;
  assign unused = ^{s00_axis_tstrb, s00_axis_tdata[31-W:0], DEEMPH_SHIFT[0]};

  // Modular subtraction wraps implicitly; exactly pi lands on -2^(W-1).
  always_comb begin
    diff     = signed'(angle - prev_q[ch_q]);
    acc_sum  = acc_q[ch_q] + AW'(diff);
    avg_full = acc_sum >>> DECIM_LOG2;
    avg      = avg_full[W-1:0];
    win_done = (win_q[ch_q] == WIN_LAST);
`ifdef FM_DEEMPH_EN
    dm_err   = W1'(avg) - W1'(y_q[ch_q]);
    dm_y     = W1'(y_q[ch_q]) + (dm_err >>> DEEMPH_SHIFT);
    res      = dm_y[W-1:0];
`else
    res      = avg;
`endif
  end

  always_comb begin
    prev_d    = prev_q;
    primed_d  = primed_q;
    acc_d     = acc_q;
    win_d     = win_q;
    sticky_d  = sticky_q;
`ifdef FM_DEEMPH_EN
    y_d       = y_q;
`endif
    ch_d      = ch_q;
    m_valid_d = m_valid_q && !m00_axis_tready;
    m_last_d  = m_last_q;
    m_res_d   = m_res_q;
    m_ch_d    = m_ch_q;
    if (accept) begin
      ch_d = (s00_axis_tlast || ch_q == CH_LAST) ? '0 : ch_q + 1'b1;
      prev_d[ch_q]   = angle;
      primed_d[ch_q] = 1'b1;
      if (!primed_q[ch_q]) begin
        sticky_d[ch_q] = sticky_q[ch_q] | s00_axis_tlast;
      end else if (win_done) begin
        m_valid_d      = 1'b1;
        m_res_d        = 16'(res);
        m_ch_d         = 8'(ch_q);
        m_last_d       = sticky_q[ch_q] | s00_axis_tlast;
        acc_d[ch_q]    = '0;
        win_d[ch_q]    = '0;
        sticky_d[ch_q] = 1'b0;
`ifdef FM_DEEMPH_EN
        y_d[ch_q]      = res;
`endif
      end else begin
        acc_d[ch_q]    = acc_sum;
        win_d[ch_q]    = win_q[ch_q] + 1'b1;
        sticky_d[ch_q] = sticky_q[ch_q] | s00_axis_tlast;
      end
    end
  end

  always_ff @(posedge s00_axis_aclk or negedge s00_axis_aresetn) begin
    if (!s00_axis_aresetn) begin
      for (int i = 0; i < NUM_CH; i++) begin
        prev_q[i]   <= '0;
        primed_q[i] <= 1'b0;
        acc_q[i]    <= '0;
        win_q[i]    <= '0;
        sticky_q[i] <= 1'b0;
`ifdef FM_DEEMPH_EN
        y_q[i]      <= '0;
`endif
      end
      ch_q      <= '0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
      m_res_q   <= '0;
      m_ch_q    <= '0;
    end else begin
      prev_q    <= prev_d;
      primed_q  <= primed_d;
      acc_q     <= acc_d;
      win_q     <= win_d;
      sticky_q  <= sticky_d;
`ifdef FM_DEEMPH_EN
      y_q       <= y_d;
`endif
      ch_q      <= ch_d;
      m_valid_q <= m_valid_d;
      m_last_q  <= m_last_d;
      m_res_q   <= m_res_d;
      m_ch_q    <= m_ch_d;
    end
  end

  assign m00_axis_tvalid = m_valid_q;
  assign m00_axis_tdata  = {8'h00, m_ch_q, m_res_q};
  assign m00_axis_tlast  = m_last_q;
  assign m00_axis_tstrb  = m_valid_q ? 4'hF : 4'h0;

endmodule

// File: tb/tb_fm_phase_discriminator.sv
// Bench for fm_phase_discriminator: two instances (single-channel, and
// 3-channel 12-bit with 4x decimation) checked against a behavioural model.
module tb_fm_phase_discriminator;
  localparam int A_W = 16, A_N = 1, A_D = 0, A_S = 1;
  localparam int B_W = 12, B_N = 3, B_D = 2, B_S = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        a_sv = 0, a_sr, a_sl = 0, a_mv, a_mr = 1, a_ml;
  logic [31:0] a_sd = 0, a_md;
  logic [3:0]  a_ss = 0, a_ms;
  logic        b_sv = 0, b_sr, b_sl = 0, b_mv, b_mr = 1, b_ml;
  logic [31:0] b_sd = 0, b_md;
  logic [3:0]  b_ss = 0, b_ms;
  logic        a_acc, b_acc;

  int total = 0;
  int bad = 0;

  fm_phase_discriminator #(
    .ANGLE_WIDTH(A_W), .NUM_CH(A_N), .DECIM_LOG2(A_D), .DEEMPH_SHIFT(A_S)
  ) dut_a (
    .s00_axis_aclk(clk), .s00_axis_aresetn(rst_n),
    .s00_axis_tvalid(a_sv), .s00_axis_tready(a_sr),
    .s00_axis_tdata(a_sd), .s00_axis_tlast(a_sl), .s00_axis_tstrb(a_ss),
    .m00_axis_tvalid(a_mv), .m00_axis_tready(a_mr),
    .m00_axis_tdata(a_md), .m00_axis_tlast(a_ml), .m00_axis_tstrb(a_ms)
  );

  fm_phase_discriminator #(
    .ANGLE_WIDTH(B_W), .NUM_CH(B_N), .DECIM_LOG2(B_D), .DEEMPH_SHIFT(B_S)
  ) dut_b (
    .s00_axis_aclk(clk), .s00_axis_aresetn(rst_n),
    .s00_axis_tvalid(b_sv), .s00_axis_tready(b_sr),
    .s00_axis_tdata(b_sd), .s00_axis_tlast(b_sl), .s00_axis_tstrb(b_ss),
    .m00_axis_tvalid(b_mv), .m00_axis_tready(b_mr),
    .m00_axis_tdata(b_md), .m00_axis_tlast(b_ml), .m00_axis_tstrb(b_ms)
  );

  // Reference model state, per instance and channel
  int m_prev [2][256];
  bit m_primed [2][256];
  int m_sum [2][256];
  int m_cnt [2][256];
  bit m_stk [2][256];
`ifdef FM_DEEMPH_EN
  int m_y [2][256];
`endif
  int mch [2];
  logic [36:0] exp_a [$];
  logic [36:0] exp_b [$];
  logic [36:0] obs_a [$];
  logic [36:0] obs_b [$];

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mch[i] = 0;
      for (int c = 0; c < 256; c++) begin
        m_prev[i][c] = 0;
        m_primed[i][c] = 0;
        m_sum[i][c] = 0;
        m_cnt[i][c] = 0;
        m_stk[i][c] = 0;
`ifdef FM_DEEMPH_EN
        m_y[i][c] = 0;
`endif
      end
    end
    exp_a.delete(); exp_b.delete();
    obs_a.delete(); obs_b.delete();
  endtask

  task automatic model_beat(input int id, input int ang, input bit last);
    int w, n, dl, c, d, avg, v;
    logic [36:0] ent;
    w  = (id == 0) ? A_W : B_W;
    n  = (id == 0) ? A_N : B_N;
    dl = (id == 0) ? A_D : B_D;
    c  = mch[id];
    if (!m_primed[id][c]) begin
      m_primed[id][c] = 1;
      m_prev[id][c] = ang;
      m_stk[id][c] = m_stk[id][c] | last;
    end else begin
      d = (ang - m_prev[id][c]) & ((1 << w) - 1);
      if (d >= (1 << (w - 1))) d = d - (1 << w);
      m_prev[id][c] = ang;
      m_sum[id][c] += d;
      m_cnt[id][c] += 1;
      if (m_cnt[id][c] == (1 << dl)) begin
        avg = m_sum[id][c] >>> dl;
`ifdef FM_DEEMPH_EN
        m_y[id][c] = m_y[id][c] + ((avg - m_y[id][c]) >>> ((id == 0) ? A_S : B_S));
        v = m_y[id][c];
`else
        v = avg;
`endif
        ent = {4'hF, m_stk[id][c] | last, 8'h00, 8'(c), 16'(v)};
        if (id == 0) exp_a.push_back(ent);
        else exp_b.push_back(ent);
        m_sum[id][c] = 0;
        m_cnt[id][c] = 0;
        m_stk[id][c] = 0;
      end else begin
        m_stk[id][c] = m_stk[id][c] | last;
      end
    end
    mch[id] = last ? 0 : (c + 1) % n;
  endtask

  // One clock: drive at negedge, sample at +1, record accepts and consumed beats.
  task automatic cycle(input bit va, input logic [15:0] aa, input bit la, input bit ra,
                       input bit vb, input logic [15:0] ab, input bit lb, input bit rb);
    a_sv = va; a_sl = la; a_mr = ra;
    a_sd = {aa, 16'($urandom())};
    a_ss = 4'($urandom());
    b_sv = vb; b_sl = lb; b_mr = rb;
    b_sd = {ab[11:0], 20'($urandom())};
    b_ss = 4'($urandom());
    #1;
    a_acc = a_sv && a_sr;
    b_acc = b_sv && b_sr;
    if (a_mv && a_mr) obs_a.push_back({a_ms, a_ml, a_md});
    if (b_mv && b_mr) obs_b.push_back({b_ms, b_ml, b_md});
    if (a_acc) model_beat(0, int'(aa), la);
    if (b_acc) model_beat(1, int'(ab[11:0]), lb);
    @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 64; i++) begin
      if (obs_a.size() == exp_a.size() && obs_b.size() == exp_b.size()
          && !a_mv && !b_mv) break;
      cycle(0, 16'h0, 0, 1, 0, 16'h0, 0, 1);
    end
  endtask

  task automatic reset_dut();
    a_sv = 0; b_sv = 0; a_sl = 0; b_sl = 0; a_mr = 1; b_mr = 1;
    rst_n = 0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 0;
    model_reset();
    @(negedge clk); #1;
    total++; if (a_mv !== 1'b0) begin bad++; $display("FAIL reset_a_tvalid got %b want 0", a_mv); end
    total++; if (a_md !== 32'h0) begin bad++; $display("FAIL reset_a_tdata got %h want 0", a_md); end
    total++; if (a_ml !== 1'b0) begin bad++; $display("FAIL reset_a_tlast got %b want 0", a_ml); end
    total++; if (a_ms !== 4'h0) begin bad++; $display("FAIL reset_a_tstrb got %h want 0", a_ms); end
    total++; if (b_mv !== 1'b0 || b_md !== 32'h0) begin bad++; $display("FAIL reset_b_out got %b/%h want 0/0", b_mv, b_md); end
    total++; if (a_sr !== 1'b1) begin bad++; $display("FAIL reset_a_tready got %b want 1", a_sr); end
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
  endtask

  task automatic test_single_channel();
    logic [15:0] seq [6];
    logic [15:0] want [5];
    seq = '{16'h0010, 16'hFFF0, 16'h0010, 16'h0000, 16'h8000, 16'h7FFF};
`ifdef FM_DEEMPH_EN
    want = '{16'hFFF0, 16'h0008, 16'hFFFC, 16'hBFFE, 16'hDFFE};
`else
    want = '{16'hFFE0, 16'h0020, 16'hFFF0, 16'h8000, 16'hFFFF};
`endif
    reset_dut();
    cycle(1, seq[0], 0, 1, 0, 16'h0, 0, 1);
    total++; if (a_mv !== 1'b0) begin bad++; $display("FAIL single_unprimed got tvalid=%b want 0", a_mv); end
    for (int i = 1; i < 6; i++) cycle(1, seq[i], 0, 1, 0, 16'h0, 0, 1);
    total++; if (a_mv !== 1'b1 || a_ms !== 4'hF) begin bad++; $display("FAIL single_latency got v=%b s=%h want 1/F", a_mv, a_ms); end
    drain();
    total++; if (obs_a.size() != 5) begin bad++; $display("FAIL single_count got %0d want 5", obs_a.size()); end
    for (int i = 0; i < 5 && i < obs_a.size(); i++) begin
      total++;
      if (obs_a[i] !== {4'hF, 1'b0, 16'h0000, want[i]}) begin
        bad++; $display("FAIL single_beat%0d got %h want %h", i, obs_a[i], {4'hF, 1'b0, 16'h0000, want[i]});
      end
      total++;
      if (i < exp_a.size() && obs_a[i] !== exp_a[i]) begin
        bad++; $display("FAIL single_model%0d got %h want %h", i, obs_a[i], exp_a[i]);
      end
    end
  endtask

  task automatic test_const_diff();
    logic [15:0] want [3];
`ifdef FM_DEEMPH_EN
    want = '{16'h0080, 16'h00C0, 16'h00E0};
`else
    want = '{16'h0100, 16'h0100, 16'h0100};
`endif
    reset_dut();
    for (int i = 0; i < 4; i++) cycle(1, 16'(i * 256), 0, 1, 0, 16'h0, 0, 1);
    drain();
    total++; if (obs_a.size() != 3) begin bad++; $display("FAIL const_count got %0d want 3", obs_a.size()); end
    for (int i = 0; i < 3 && i < obs_a.size(); i++) begin
      total++;
      if (obs_a[i][15:0] !== want[i]) begin
        bad++; $display("FAIL const_beat%0d got %h want %h", i, obs_a[i][15:0], want[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [36:0] held;
    int k;
    k = 0;
    held = '0;
    cycle(1, 16'h1F00, 0, 1, 0, 16'h0, 0, 1);
    cycle(1, 16'h2000, 0, 1, 0, 16'h0, 0, 1);
    drain();
    exp_a.delete(); obs_a.delete();
    for (int c = 0; c < 5; c++) begin
      cycle(k < 3, 16'h2000 + 16'((k + 1) * 'h300), 0, 0, 0, 16'h0, 0, 1);
      if (a_acc) k++;
      if (c == 0) held = {a_ms, a_ml, a_md};
      else begin
        total++;
        if ({a_ms, a_ml, a_md} !== held) begin
          bad++; $display("FAIL bp_hold%0d got %h want %h", c, {a_ms, a_ml, a_md}, held);
        end
      end
      total++;
      if (a_sr !== 1'b0 || a_mv !== 1'b1) begin
        bad++; $display("FAIL bp_stall%0d got tready=%b tvalid=%b want 0/1", c, a_sr, a_mv);
      end
    end
    total++; if (k != 1) begin bad++; $display("FAIL bp_accepted got %0d want 1", k); end
    for (int c = 0; c < 20 && k < 3; c++) begin
      cycle(1, 16'h2000 + 16'((k + 1) * 'h300), 0, 1, 0, 16'h0, 0, 1);
      if (a_acc) k++;
    end
    drain();
    total++; if (obs_a.size() != 3 || exp_a.size() != 3) begin
      bad++; $display("FAIL bp_count got %0d want 3", obs_a.size());
    end
    for (int i = 0; i < exp_a.size() && i < obs_a.size(); i++) begin
      total++;
      if (obs_a[i] !== exp_a[i]) begin
        bad++; $display("FAIL bp_beat%0d got %h want %h", i, obs_a[i], exp_a[i]);
      end
    end
  endtask

  task automatic test_decim_tlast();
    logic [15:0] ch0 [5];
    logic [15:0] want;
    int j;
    ch0 = '{16'h100, 16'h104, 16'h108, 16'h110, 16'h10F};
`ifdef FM_DEEMPH_EN
    want = 16'h0000;
`else
    want = 16'h0003;
`endif
    reset_dut();
    j = 0;
    for (int b = 0; b < 11; b++) begin
      if (b == 0 || b == 3 || b == 4 || b == 7 || b == 10) begin
        cycle(0, 16'h0, 0, 1, 1, ch0[j], b == 3, 1);
        j++;
      end else begin
        cycle(0, 16'h0, 0, 1, 1, 16'($urandom()), 0, 1);
      end
    end
    drain();
    total++; if (obs_b.size() != 1) begin bad++; $display("FAIL decim_count got %0d want 1", obs_b.size()); end
    if (obs_b.size() > 0) begin
      total++;
      if (obs_b[0] !== {4'hF, 1'b1, 16'h0000, want}) begin
        bad++; $display("FAIL decim_beat got %h want %h", obs_b[0], {4'hF, 1'b1, 16'h0000, want});
      end
      total++;
      if (exp_b.size() > 0 && obs_b[0] !== exp_b[0]) begin
        bad++; $display("FAIL decim_model got %h want %h", obs_b[0], exp_b[0]);
      end
    end
  endtask

  task automatic test_random();
    reset_dut();
    for (int i = 0; i < 1500; i++) begin
      cycle($urandom_range(0, 9) < 7, 16'($urandom()), $urandom_range(0, 15) == 0,
            $urandom_range(0, 9) < 7,
            $urandom_range(0, 9) < 7, 16'($urandom()), $urandom_range(0, 15) == 0,
            $urandom_range(0, 9) < 7);
    end
    drain();
    total++; if (obs_a.size() != exp_a.size()) begin bad++; $display("FAIL rand_a_count got %0d want %0d", obs_a.size(), exp_a.size()); end
    total++; if (obs_b.size() != exp_b.size()) begin bad++; $display("FAIL rand_b_count got %0d want %0d", obs_b.size(), exp_b.size()); end
    for (int i = 0; i < exp_a.size() && i < obs_a.size(); i++) begin
      total++;
      if (obs_a[i] !== exp_a[i]) begin bad++; $display("FAIL rand_a%0d got %h want %h", i, obs_a[i], exp_a[i]); end
    end
    for (int i = 0; i < exp_b.size() && i < obs_b.size(); i++) begin
      total++;
      if (obs_b[i] !== exp_b[i]) begin bad++; $display("FAIL rand_b%0d got %h want %h", i, obs_b[i], exp_b[i]); end
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] want;
`ifdef FM_DEEMPH_EN
    want = 16'h0080;
`else
    want = 16'h0100;
`endif
    reset_dut();
    cycle(1, 16'h1000, 0, 1, 1, 16'h0100, 0, 1);
    cycle(1, 16'h1040, 0, 0, 1, 16'h0120, 0, 1);
    total++; if (a_mv !== 1'b1) begin bad++; $display("FAIL rstmid_pending got %b want 1", a_mv); end
    a_sv = 0; b_sv = 0;
    #2 rst_n = 0;
    #1;
    total++; if (a_mv !== 1'b0 || a_md !== 32'h0) begin bad++; $display("FAIL rstmid_a_out got %b/%h want 0/0", a_mv, a_md); end
    total++; if (a_ml !== 1'b0 || a_ms !== 4'h0) begin bad++; $display("FAIL rstmid_a_side got %b/%h want 0/0", a_ml, a_ms); end
    total++; if (b_mv !== 1'b0) begin bad++; $display("FAIL rstmid_b_tvalid got %b want 0", b_mv); end
    model_reset();
    @(negedge clk);
    rst_n = 1;
    cycle(1, 16'h4000, 0, 1, 0, 16'h0, 0, 1);
    cycle(0, 16'h0, 0, 1, 0, 16'h0, 0, 1);
    cycle(0, 16'h0, 0, 1, 0, 16'h0, 0, 1);
    total++; if (obs_a.size() != 0 || a_mv !== 1'b0) begin bad++; $display("FAIL rstmid_unprimed got %0d beats want 0", obs_a.size()); end
    cycle(1, 16'h4100, 0, 1, 0, 16'h0, 0, 1);
    drain();
    total++; if (obs_a.size() != 1) begin bad++; $display("FAIL rstmid_count got %0d want 1", obs_a.size()); end
    if (obs_a.size() > 0) begin
      total++;
      if (obs_a[0][15:0] !== want) begin bad++; $display("FAIL rstmid_value got %h want %h", obs_a[0][15:0], want); end
    end
  endtask

  initial begin
    test_reset();
    test_single_channel();
    test_const_diff();
    test_backpressure();
    test_decim_tlast();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fm_phase_discriminator.md
# fm_phase_discriminator

Parametrised, multi-channel FM phase discriminator for the receive chain. It sits downstream of the CORDIC magnitude/angle stage and upstream of the audio filter/decimator. For each channel it computes the modulo-2π phase difference between consecutive angle samples. It optionally averages N differences for decimation and emits a signed frequency word on an AXI-Stream master with a one-beat output register.

## Interface
- ANGLE_WIDTH, 16: bits of phase; input angle is unsigned, full scale 2^ANGLE_WIDTH = 2π; legal 8..16
- NUM_CH, 1: interleaved channels, round-robin; legal 1..256
- DECIM_LOG2, 0: average 2^DECIM_LOG2 differences per output; legal 0..4
- DEEMPH_SHIFT, 4: de-emphasis pole shift (used only with FM_DEEMPH_EN); legal 1..15
- s00_axis_aclk  in  1  single clock for both interfaces
- s00_axis_aresetn  in  1  asynchronous, active-low reset
- s00_axis_tvalid / s00_axis_tready  in / out  1  input handshake
- s00_axis_tdata  in  32  [31:32-ANGLE_WIDTH] angle; remaining bits ignored
- s00_axis_tlast  in  1  end of frame; also resets the channel counter
- s00_axis_tstrb  in  4  ignored
- m00_axis_tvalid / m00_axis_tready  out / in  1  output handshake
- m00_axis_tdata  out  32  [15:0] signed result sign-extended from ANGLE_WIDTH; [23:16] channel index; [31:24] zero
- m00_axis_tlast  out  1  frame end (see Operation)
- m00_axis_tstrb  out  4  4'hF when valid, else 0

## Operation
- Beat accepted when s00_axis_tvalid && s00_axis_tready; s00_axis_tready = m00_axis_tready || !m00_axis_tvalid, combinational.
- Channel counter ch: accepted beat belongs to ch. After acceptance ch increments, wrapping NUM_CH-1 -> 0. Accepted tlast forces ch to 0.
- Per-channel state: prev angle, primed flag, accumulator (ANGLE_WIDTH+DECIM_LOG2 bits signed), window counter, sticky tlast, de-emphasis state.
- Unprimed channel: store angle, set primed, no difference, no output; tlast on this beat is latched into sticky.
- Primed channel: d = angle - prev in ANGLE_WIDTH-bit two's complement, interpreted signed. Range [-2^(W-1), 2^(W-1)-1], so wrap is implicit. Exactly π (difference 2^(W-1)) yields -2^(W-1). Update prev; acc += d; window++.
- Window complete (count reaches 2^DECIM_LOG2): avg = acc >>> DECIM_LOG2 (arithmetic, floor). Load the output register with avg or its de-emphasised value. m00_axis_tlast = sticky OR this beat's tlast. Clear acc, window and sticky.
- Incomplete window: no output; sticky |= tlast.
- No saturation is needed: avg always fits in ANGLE_WIDTH bits.

## Timing
- Latency: output valid the cycle after the completing input beat is accepted; full throughput, one beat per clock.
- m00_axis_tdata/tlast/tstrb are held stable while tvalid && !tready.
- An accept that completes a window and a simultaneous output consume in the same cycle: tvalid stays 1 with new data.
- Output consumed with no new completion: tvalid falls next cycle.
- Reset (async assert, synchronous release): m00_axis_tvalid=0, tdata=0, tlast=0, tstrb=0, ch=0; all per-channel state is cleared and unprimed. Reset mid-window discards partial accumulation and any pending output beat.

## Configuration
- FM_DEEMPH_EN defined: per-channel one-pole IIR y <= y + ((avg - y) >>> DEEMPH_SHIFT), computed in ANGLE_WIDTH+1 bits. Emitted value is the new y; y resets to 0. Adds no latency.
- FM_DEEMPH_EN undefined: avg is emitted directly; no de-emphasis state is synthesised. DEEMPH_SHIFT is ignored.

## Test plan
- Defaults, angles 0x0010 then 0xFFF0 -> first beat yields no output; second yields tdata[15:0]=0xFFE0 (-32), ch 0; then 0x0010 -> 0x0020.
- Defaults, 0x0000 then 0x8000 -> 0x8000 (-π); then 0x7FFF -> 0xFFFF.
- NUM_CH=2, beats A0=0x1000, B0=0x2000, A1=0x1100, B1=0x1F00 -> outputs {ch0, 0x0100}, {ch1, 0xFF00}. A tlast on B1 reorders nothing; the next beat is ch 0.
- DECIM_LOG2=2, diffs +4,+4,+8,-1 -> single output 0x0003 after fourth difference. tlast on the second beat -> output tlast=1.
- m00_axis_tready held low 5 cycles with 3 inputs offered -> one held output, s00_axis_tready=0, no data loss; release -> remaining outputs in order.
- FM_DEEMPH_EN, DEEMPH_SHIFT=1, constant diff 0x0100 -> 0x0080, 0x00C0, 0x00E0. Assert reset mid-stream -> all outputs 0 immediately, next first beat is unprimed.
